// File: rtl/march_pkg.sv
// Shared types and constants for the alien-fleet march scheduler.
// Movement codes match the fleet-position datapath encoding.
package march_pkg;

    localparam int PERIOD_W = 26;

    typedef logic [PERIOD_W-1:0] period_t;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_DOWN  = 2'b11
    } move_dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_REQ
    } state_t;

    // Speed-up after a kill, clamped so the period never drops below the floor.
    function automatic period_t kill_period(input period_t cur,
                                            input period_t floor_p,
                                            input period_t dec);
        if (cur <= floor_p + dec)
            return floor_p;
        return cur - dec;
    endfunction

endpackage

// File: rtl/march_scheduler_step_timer.sv
// Loadable down-counter for the march step period.
// Stops at zero so a held or late tick never wraps around.
module step_timer
    import march_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    load,
    input  logic    hold,
    input  period_t load_value,
    output logic    zero
);

    period_t count_reg;

    always_ff @(posedge clk) begin
        if (reset)
            count_reg <= '0;
        else if (load)
            count_reg <= load_value;
        else if (!hold && count_reg != '0)
            count_reg <= count_reg - period_t'(1);
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/march_scheduler.sv
// Alien-fleet march sequencer: paces moves with a programmable step period
// and hands each move to the fleet datapath through a req/ack handshake.
module march_scheduler
    import march_pkg::*;
#(
    parameter period_t    BASE_PERIOD   = 26'd5000000,
    parameter period_t    MIN_PERIOD    = 26'd250000,
    parameter period_t    PERIOD_DEC    = 26'd100000,
    parameter logic [3:0] STEPS_PER_ROW = 4'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        pause,
    input  logic        alien_killed,
    input  logic        level_up,
    input  logic        move_ack,
    output logic        move_req,
    output logic [1:0]  move_dir,
    output logic [25:0] period_out
);

    state_t     state_reg, state_next;
    period_t    period_reg, period_next;
    logic       dir_right_reg, dir_right_next;
    logic [3:0] step_cnt_reg, step_cnt_next;
    logic       move_req_reg, move_req_next;
    move_dir_t  move_dir_reg, move_dir_next;

    logic       timer_load;
    logic       timer_hold;
    period_t    timer_load_value;
    logic       timer_zero;

    step_timer u_step_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .hold       (timer_hold),
        .load_value (timer_load_value),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            period_reg    <= BASE_PERIOD;
            dir_right_reg <= 1'b1;
            step_cnt_reg  <= '0;
            move_req_reg  <= 1'b0;
            move_dir_reg  <= DIR_NONE;
        end else begin
            state_reg     <= state_next;
            period_reg    <= period_next;
            dir_right_reg <= dir_right_next;
            step_cnt_reg  <= step_cnt_next;
            move_req_reg  <= move_req_next;
            move_dir_reg  <= move_dir_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        period_next      = period_reg;
        dir_right_next   = dir_right_reg;
        step_cnt_next    = step_cnt_reg;
        move_req_next    = move_req_reg;
        move_dir_next    = move_dir_reg;
        timer_load       = 1'b0;
        timer_hold       = 1'b1;
        timer_load_value = period_reg - period_t'(1);

        // Period bookkeeping applies even while disabled; a level change beats a kill.
        if (level_up) begin
            period_next    = BASE_PERIOD;
            dir_right_next = 1'b1;
            step_cnt_next  = '0;
        end else if (alien_killed) begin
            period_next = kill_period(period_reg, MIN_PERIOD, PERIOD_DEC);
        end

        if (!enable) begin
            state_next    = ST_IDLE;
            move_req_next = 1'b0;
            move_dir_next = DIR_NONE;
        end else if (level_up) begin
            state_next       = ST_COUNT;
            move_req_next    = 1'b0;
            move_dir_next    = DIR_NONE;
            timer_load       = 1'b1;
            timer_load_value = BASE_PERIOD - period_t'(1);
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_COUNT;
                    timer_load = 1'b1;
                end
                ST_COUNT: begin
                    if (!pause) begin
                        if (timer_zero) begin
                            state_next    = ST_REQ;
                            move_req_next = 1'b1;
                            if (step_cnt_reg == STEPS_PER_ROW)
                                move_dir_next = DIR_DOWN;
                            else
                                move_dir_next = dir_right_reg ? DIR_RIGHT : DIR_LEFT;
                        end else begin
                            timer_hold = 1'b0;
                        end
                    end
                end
                ST_REQ: begin
                    if (move_ack) begin
                        state_next    = ST_COUNT;
                        move_req_next = 1'b0;
                        move_dir_next = DIR_NONE;
                        timer_load    = 1'b1;
                        if (move_dir_reg == DIR_DOWN) begin
                            step_cnt_next  = '0;
                            dir_right_next = !dir_right_reg;
                        end else begin
                            step_cnt_next = step_cnt_reg + 4'd1;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign move_req   = move_req_reg;
    assign move_dir   = move_dir_reg;
    assign period_out = period_reg;

endmodule
